// File: rtl/dotn_acc.sv
// dotn_acc: pipelined LANES-wide signed dot product with multi-beat group accumulation
module dotn_acc #(
   parameter int LANES = 8,
   parameter int IWIDTH = 8,
   parameter int OWIDTH = 32,
   parameter int MUL_LAT = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [LANES*IWIDTH-1:0]   vec0,
   input  logic [LANES*IWIDTH-1:0]   vec1,
   input  logic                      ivalid,
   input  logic                      ilast,
   output logic [OWIDTH-1:0]         result,
   output logic                      ovalid,
   output logic                      ovf
);
   localparam int LOG = $clog2(LANES);
   localparam int PW = 2 * IWIDTH;
   localparam int TW = PW + LOG;
   localparam int D = 1 + MUL_LAT + LOG;
   if (OWIDTH < TW) begin : g_bad_ow
      $error("dotn_acc: OWIDTH must be >= 2*IWIDTH+clog2(LANES)");
   end
   if (LANES < 2 || (1 << LOG) != LANES) begin : g_bad_lanes
      $error("dotn_acc: LANES must be a power of 2 and >= 2");
   end
   if (MUL_LAT < 1) begin : g_bad_lat
      $error("dotn_acc: MUL_LAT must be >= 1");
   end
   logic signed [IWIDTH-1:0] a [LANES];
   logic signed [IWIDTH-1:0] b [LANES];
   logic signed [PW-1:0]     p [MUL_LAT][LANES];
   always_ff @(posedge clk) begin
      for (int n = 0; n < LANES; n++) begin
         a[n] <= vec0[(LANES-1-n)*IWIDTH +: IWIDTH];
         b[n] <= vec1[(LANES-1-n)*IWIDTH +: IWIDTH];
         p[0][n] <= PW'(a[n]) * PW'(b[n]);
      end
      for (int n = 1; n < MUL_LAT; n++) p[n] <= p[n-1];
   end
   // every tree node carries the full final width; values never exceed their level's range
   for (genvar k = 0; k <= LOG; k++) begin : lvl
      logic signed [TW-1:0] s [LANES >> k];
      if (k == 0) begin : g_leaf
         always_comb
            for (int n = 0; n < LANES; n++) s[n] = TW'(p[MUL_LAT-1][n]);
      end else begin : g_add
         always_ff @(posedge clk)
            for (int n = 0; n < (LANES >> k); n++) s[n] <= lvl[k-1].s[2*n] + lvl[k-1].s[2*n+1];
      end
   end
   logic [D-1:0] vs, ls;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         vs <= '0;
         ls <= '0;
      end else begin
         vs <= {vs[D-2:0], ivalid};
         ls <= {ls[D-2:0], ivalid & ilast};
      end
   logic signed [OWIDTH-1:0] acc, tx, sum, nacc;
   logic ovf_acc, first, sov, novf;
   assign tx = OWIDTH'(lvl[LOG].s[0]);
   always_comb begin
      sum = acc + tx;
      sov = (acc[OWIDTH-1] == tx[OWIDTH-1]) && (sum[OWIDTH-1] != acc[OWIDTH-1]);
      nacc = first ? tx : sum;
      novf = first ? 1'b0 : (ovf_acc | sov);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc <= '0;
         ovf_acc <= 1'b0;
         first <= 1'b1;
         result <= '0;
         ovf <= 1'b0;
         ovalid <= 1'b0;
      end else begin
         ovalid <= vs[D-1] & ls[D-1];
         if (vs[D-1]) begin
            acc <= nacc;
            ovf_acc <= novf;
            first <= ls[D-1];
         end
         if (vs[D-1] & ls[D-1]) begin
            result <= nacc;
            ovf <= novf;
         end
      end
endmodule

// File: tb/tb_dotn_acc.sv
// tb_dotn_acc: directed table-driven and sequence checks of dotn_acc (32-bit and 19-bit accumulators)
module tb_dotn_acc;
   localparam int L = 8;
   localparam int W = 8;
   logic clk = 1'b0, rst_n = 1'b1, ivalid = 1'b0, ilast = 1'b0;
   logic [L*W-1:0] vec0 = '0, vec1 = '0;
   logic [31:0] result;
   logic [18:0] result19;
   logic ovalid, ovf, ovalid19, ovf19;
   int checks = 0, failures = 0;
   dotn_acc #(.LANES(L), .IWIDTH(W), .OWIDTH(32), .MUL_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .vec0(vec0), .vec1(vec1), .ivalid(ivalid), .ilast(ilast),
      .result(result), .ovalid(ovalid), .ovf(ovf));
   dotn_acc #(.LANES(L), .IWIDTH(W), .OWIDTH(19), .MUL_LAT(2)) dut19 (
      .clk(clk), .rst_n(rst_n), .vec0(vec0), .vec1(vec1), .ivalid(ivalid), .ilast(ilast),
      .result(result19), .ovalid(ovalid19), .ovf(ovf19));
   always #5 clk = ~clk;
   typedef struct {
      logic [L*W-1:0] a;
      logic [L*W-1:0] b;
      longint         res;
      logic           ov;
   } vec_t;
   vec_t tv [7];
   function automatic logic [L*W-1:0] rep(input int v);
      logic [L*W-1:0] r;
      for (int n = 0; n < L; n++) r[n*W +: W] = W'(v);
      return r;
   endfunction
   function automatic logic [L*W-1:0] seq(input int base);
      logic [L*W-1:0] r;
      for (int n = 0; n < L; n++) r[(L-1-n)*W +: W] = W'(base + n);
      return r;
   endfunction
   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic beat(input logic [L*W-1:0] x, input logic [L*W-1:0] y, input logic last);
      @(posedge clk);
      #1;
      vec0 = x;
      vec1 = y;
      ivalid = 1'b1;
      ilast = last;
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         ivalid = 1'b0;
         ilast = 1'b0;
      end
   endtask
   task automatic wait_out(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!ovalid && cyc < 30);
      check("ovalid_seen", longint'(ovalid), 1);
   endtask
   task automatic quiet(input string nm, input int n);
      logic seen;
      seen = 1'b0;
      repeat (n) begin
         @(negedge clk);
         seen = seen | ovalid | ovalid19;
      end
      check(nm, longint'(seen), 0);
   endtask
   initial begin
      int c;
      tv[0] = '{rep(127),  rep(127),  129032, 1'b0};
      tv[1] = '{rep(-128), rep(-128), 131072, 1'b0};
      tv[2] = '{rep(-128), rep(127), -130048, 1'b0};
      tv[3] = '{rep(0),    rep(0),    0,      1'b0};
      tv[4] = '{seq(1),    rep(1),    36,     1'b0};
      tv[5] = '{seq(1),    rep(-1),  -36,     1'b0};
      tv[6] = '{rep(1),    rep(1),    8,      1'b0};
      #2 rst_n = 1'b0;
      #1;
      check("rst_result", longint'(result), 0);
      check("rst_ovalid", longint'(ovalid), 0);
      check("rst_ovf", longint'(ovf), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      for (int t = 0; t < 7; t++) begin
         beat(tv[t].a, tv[t].b, 1'b1);
         idle(1);
         wait_out(c);
         check($sformatf("tv%0d_latency", t), c, 7);
         check($sformatf("tv%0d_result", t), longint'($signed(result)), tv[t].res);
         check($sformatf("tv%0d_ovf", t), longint'(ovf), longint'(tv[t].ov));
         check($sformatf("tv%0d_valid19", t), longint'(ovalid19), 1);
         check($sformatf("tv%0d_result19", t), longint'($signed(result19)), tv[t].res);
         @(negedge clk);
         check($sformatf("tv%0d_pulse", t), longint'(ovalid), 0);
         check($sformatf("tv%0d_hold", t), longint'($signed(result)), tv[t].res);
      end
      beat(seq(1), rep(1), 1'b0);
      beat(rep(2), rep(3), 1'b0);
      beat(rep(-1), rep(5), 1'b1);
      idle(1);
      wait_out(c);
      check("grp3_latency", c, 7);
      check("grp3_result", longint'($signed(result)), 44);
      @(negedge clk);
      check("grp3_pulse", longint'(ovalid), 0);
      beat(seq(1), rep(1), 1'b0);
      idle(5);
      beat(rep(2), rep(3), 1'b0);
      idle(5);
      beat(rep(-1), rep(5), 1'b1);
      idle(1);
      wait_out(c);
      check("grp3b_latency", c, 7);
      check("grp3b_result", longint'($signed(result)), 44);
      beat(rep(1), rep(1), 1'b1);
      beat(rep(2), rep(2), 1'b1);
      beat(rep(3), rep(3), 1'b1);
      idle(1);
      wait_out(c);
      check("b2b_latency", c, 5);
      check("b2b_result0", longint'($signed(result)), 8);
      @(negedge clk);
      check("b2b_valid1", longint'(ovalid), 1);
      check("b2b_result1", longint'($signed(result)), 32);
      @(negedge clk);
      check("b2b_valid2", longint'(ovalid), 1);
      check("b2b_result2", longint'($signed(result)), 72);
      @(negedge clk);
      check("b2b_end", longint'(ovalid), 0);
      beat(rep(-128), rep(-128), 1'b0);
      beat(rep(-128), rep(-128), 1'b1);
      idle(1);
      wait_out(c);
      check("wrap_result19", longint'($signed(result19)), -262144);
      check("wrap_ovf19", longint'(ovf19), 1);
      check("wrap_result32", longint'($signed(result)), 262144);
      check("wrap_ovf32", longint'(ovf), 0);
      beat(rep(0), rep(0), 1'b1);
      idle(1);
      wait_out(c);
      check("after_wrap_result19", longint'($signed(result19)), 0);
      check("after_wrap_ovf19", longint'(ovf19), 0);
      beat(rep(127), rep(127), 1'b1);
      idle(1);
      wait_out(c);
      check("pre_rst_result", longint'($signed(result)), 129032);
      beat(rep(5), rep(5), 1'b0);
      beat(rep(6), rep(6), 1'b0);
      idle(2);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_result", longint'(result), 0);
      check("mid_rst_ovalid", longint'(ovalid), 0);
      check("mid_rst_ovf", longint'(ovf), 0);
      check("mid_rst_result19", longint'(result19), 0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet("mid_rst_no_ovalid", 20);
      beat(rep(3), rep(3), 1'b1);
      idle(2);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      quiet("inflight_last_dropped", 20);
      beat(rep(1), rep(1), 1'b1);
      idle(1);
      wait_out(c);
      check("post_rst_latency", c, 7);
      check("post_rst_result", longint'($signed(result)), 8);
      check("post_rst_ovf", longint'(ovf), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
